// File: rtl/mux_8_rr_arbiter.sv
// Round-robin arbiter for an 8:1 32-bit select mux; registered grant/select, 1-edge request-to-grant latency.
// A holder keeps the grant while requesting; the hold limit forces rotation only when others are waiting.
module mux_8_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] req,
  output logic [7:0] grant,
  output logic [2:0] select,
  output logic       grant_valid,
  output logic       preempt
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  state_t            state, state_nxt;
  logic [2:0]        ptr, ptr_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [7:0]        grant_nxt;
  logic [2:0]        select_nxt;
  logic              valid_nxt;
  logic              preempt_nxt;

  logic [2:0]        pick_idx;
  logic              req_any;
  logic              cur_req;
  logic              contend;
  logic              switch_en;

  // First set request bit searching from ptr upward, wrapping mod 8.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    logic       found;
    rr_pick = p;
    found   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = p + 3'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign pick_idx = rr_pick(req, ptr);
  assign req_any  = |req;
  assign cur_req  = req[select];
  assign contend  = |(req & ~grant);

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    select_nxt  = select;
    valid_nxt   = grant_valid;
    preempt_nxt = 1'b0;
    ptr_nxt     = ptr;
    hold_nxt    = hold_cnt;
    switch_en   = 1'b0;

    case (state)
      IDLE: begin
        if (req_any) begin
          switch_en = 1'b1;
          valid_nxt = 1'b1;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (!cur_req) begin
          if (req_any) begin
            switch_en = 1'b1;
          end else begin
            grant_nxt = '0;
            valid_nxt = 1'b0;
            state_nxt = IDLE;
          end
        end else if ((hold_cnt == HOLD_LAST) && contend) begin
          // ptr already sits past the holder, so the pick lands on a competitor.
          switch_en   = 1'b1;
          preempt_nxt = 1'b1;
        end else if (hold_cnt != HOLD_LAST) begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (switch_en) begin
      grant_nxt  = 8'b1 << pick_idx;
      select_nxt = pick_idx;
      ptr_nxt    = pick_idx + 3'd1;
      hold_nxt   = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant       <= '0;
      select      <= '0;
      grant_valid <= 1'b0;
      preempt     <= 1'b0;
      ptr         <= '0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      grant       <= grant_nxt;
      select      <= select_nxt;
      grant_valid <= valid_nxt;
      preempt     <= preempt_nxt;
      ptr         <= ptr_nxt;
      hold_cnt    <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_mux_8_rr_arbiter.sv
// Directed bench for mux_8_rr_arbiter: one instance with MAX_HOLD=4, one with MAX_HOLD=1.
module tb_mux_8_rr_arbiter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] select;
  logic       grant_valid;
  logic       preempt;

  logic [7:0] req1;
  logic [7:0] grant1;
  logic [2:0] select1;
  logic       grant_valid1;
  logic       preempt1;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  mux_8_rr_arbiter #(.MAX_HOLD(4), .HOLD_W(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .grant      (grant),
    .select     (select),
    .grant_valid(grant_valid),
    .preempt    (preempt)
  );

  mux_8_rr_arbiter #(.MAX_HOLD(1), .HOLD_W(4)) dut1 (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req1),
    .grant      (grant1),
    .select     (select1),
    .grant_valid(grant_valid1),
    .preempt    (preempt1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] g, input logic [2:0] s,
                         input logic v, input logic p);
    chk({tag, ".grant"},   grant,               g);
    chk({tag, ".select"},  8'(select),          8'(s));
    chk({tag, ".valid"},   8'(grant_valid),     8'(v));
    chk({tag, ".preempt"}, 8'(preempt),         8'(p));
  endtask

  initial begin
    logic [7:0] r;
    logic [2:0] es;
    logic       ep;

    reset_n = 1'b0;
    req     = 8'h00;
    req1    = 8'h00;
    #2;
    chk_all("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    reset_n = 1'b1;

    // Single requester, then release: select holds.
    req = 8'h08;
    step();
    chk_all("single", 8'h08, 3'd3, 1'b1, 1'b0);
    req = 8'h00;
    step();
    chk_all("single_rel", 8'h00, 3'd3, 1'b0, 1'b0);

    // Round robin from ptr=0, each grantee drops its bit after being granted.
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    r = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      req = r;
      step();
      chk("rr.grant",   grant,       8'b1 << i);
      chk("rr.preempt", 8'(preempt), 8'h00);
      r = r & ~(8'b1 << i);
    end
    req = 8'h00;
    step();
    chk("rr_idle.valid", 8'(grant_valid), 8'h00);

    // Wrap: grant 6, release, then 0x41 searches from 7 and wraps to 0.
    req = 8'h40;
    step();
    chk("wrap.sel6", 8'(select), 8'd6);
    req = 8'h00;
    step();
    req = 8'h41;
    step();
    chk("wrap.sel0", 8'(select), 8'd0);
    req = 8'h40;
    step();
    chk("wrap.back6", 8'(select), 8'd6);
    req = 8'h00;
    step();

    // Preemption with MAX_HOLD=4 and constant contention.
    req = 8'h03;
    for (int e = 1; e <= 12; e++) begin
      step();
      es = ((e - 1) / 4) % 2 == 1 ? 3'd1 : 3'd0;
      ep = (e == 5) || (e == 9);
      chk("hold.select",  8'(select),  8'(es));
      chk("hold.preempt", 8'(preempt), 8'(ep));
    end
    req = 8'h00;
    step();
    chk("hold_idle.valid", 8'(grant_valid), 8'h00);

    // Saturation: sole requester keeps grant; late competitor preempts next edge.
    req = 8'h04;
    for (int e = 0; e < 10; e++) begin
      step();
      chk("sat.select",  8'(select),  8'd2);
      chk("sat.preempt", 8'(preempt), 8'h00);
    end
    req = 8'h24;
    step();
    chk_all("sat_pre", 8'h20, 3'd5, 1'b1, 1'b1);
    step();
    chk_all("sat_after", 8'h20, 3'd5, 1'b1, 1'b0);

    // Reset mid-grant clears outputs asynchronously.
    req = 8'h10;
    step();
    chk_all("mid.pre", 8'h10, 3'd4, 1'b1, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    chk_all("mid.async", 8'h00, 3'd0, 1'b0, 1'b0);
    step();
    reset_n = 1'b1;
    step();
    chk_all("mid.regrant", 8'h10, 3'd4, 1'b1, 1'b0);

    // ptr restarts from 0: a stale ptr of 5 would pick 7 here.
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    req = 8'h81;
    step();
    chk_all("ptr_restart", 8'h01, 3'd0, 1'b1, 1'b0);
    req = 8'h00;

    // MAX_HOLD=1: contention rotates every cycle with a preempt each switch.
    req1 = 8'h03;
    step();
    chk("mh1.grant0",   grant1,       8'h01);
    chk("mh1.preempt0", 8'(preempt1), 8'h00);
    for (int e = 1; e <= 4; e++) begin
      step();
      chk("mh1.grant",   grant1,       (e % 2 == 1) ? 8'h02 : 8'h01);
      chk("mh1.preempt", 8'(preempt1), 8'h01);
    end
    req1 = 8'h00;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_8_rr_arbiter.md
Name: mux_8_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8-input, 32-bit select mux among 8 requesters.
- Drives the mux's 3-bit select, plus a one-hot grant and a valid flag back to the requesters.
- A grant is held while its requester keeps its request high; a hold limit forces rotation when others are waiting, to guarantee fairness.
- Sits between the requesting units and the mux; the datapath itself is outside this block.

Parameters:
MAX_HOLD, 16, max consecutive grant cycles before forced rotation under contention; legal range 1..2^HOLD_W.
HOLD_W, 4, width of hold counter.

Ports:
clock  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
req  input  8  request per requester; bit i = requester i.
grant  output  8  one-hot grant, registered; all-zero when idle.
select  output  3  encoded index of granted requester, registered; drives the mux select.
grant_valid  output  1  high when grant is non-zero.
preempt  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset (reset_n low, async, any state): grant=0, select=0, grant_valid=0, preempt=0, ptr=0, hold_cnt=0, state=IDLE. Release is synchronous to the next clock edge.
- ptr (3b): first index searched. Search order is ptr, ptr+1, ..., wrapping mod 8. After granting index k, ptr<=k+1 mod 8 (7 wraps to 0).
- pick(): first set req bit in search order.
- State IDLE:
  - req==0: stay IDLE; outputs unchanged (select holds last value).
  - req!=0: grant<=onehot(pick), select<=pick, grant_valid<=1, hold_cnt<=0, state<=GRANT.
  - Latency: request to grant visible = 1 clock edge.
- State GRANT (cur = select), evaluated each edge in priority order:
  1. req[cur]==0 and req!=0: switch to pick(); hold_cnt<=0; preempt<=0.
  2. req[cur]==0 and req==0: grant<=0, grant_valid<=0, state<=IDLE; select holds.
  3. req[cur]==1, hold_cnt==MAX_HOLD-1, and (req & ~grant)!=0: forced switch to pick(); hold_cnt<=0; preempt<=1.
  4. Otherwise: keep grant. hold_cnt<=hold_cnt+1, saturating at MAX_HOLD-1.
- Because of the saturation in rule 4, a sole requester keeps the grant indefinitely. A competitor arriving after saturation causes preemption on the next edge.
- On any switch, ptr advances past the new grantee. cur is never re-picked by a forced switch because ptr is already cur+1 and a competitor exists.
- preempt is 0 on every edge except a rule-3 edge.
- MAX_HOLD=1: under contention, grant rotates every cycle.
- grant is always one-hot or zero. select==index(grant) whenever grant_valid=1.
- Request bits that drop or rise mid-cycle are sampled only at the edge. No combinational path from req to outputs.

Test Plan:
- Single requester: reset; req=0x08 -> after 1 edge grant=0x08, select=3, grant_valid=1; req=0x00 -> next edge grant=0, grant_valid=0, select stays 3.
- Round robin: req=0xFF; each grantee drops its bit the cycle after being granted -> grant sequence 0x01,0x02,...,0x80; preempt stays 0.
- Wrap: grant index 6 then release; req=0x41 -> next grant select=0 (ptr=7, search wraps), then select=6.
- Preemption, MAX_HOLD=4: req=0x03 held constant.
  - select=0 for 4 cycles, then 1 for 4, then 0 again.
  - preempt pulses exactly on each switch edge.
- Saturation, MAX_HOLD=4: req=0x04 alone for 10 cycles, grant held. Then raise req to 0x24 -> next edge select=5, preempt=1.
- Reset mid-grant: while grant=0x10, drive reset_n low between edges -> grant=0, select=0, grant_valid=0 immediately. After release with req=0x10 -> grant 0x10 one edge later, and ptr restarts from 0.
